// File: rtl/ieee_div.sv
// Iterative IEEE-754 single divider, one quotient bit/cycle; latency 27 (28 with IEEE_DIV_ROUND_NEAREST_EN), specials 1.
// Single op in flight: in_ready only in IDLE, result held until out_ready; IEEE_DIV_ROUND_NEAREST_EN selects RNE over truncation.
module ieee_div #(
    parameter int EXP_BIAS = 127,
    parameter int MANT_W   = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic        div_by_zero
);
    localparam int EW = 31 - MANT_W;
    localparam int MW = MANT_W + 1;
`ifdef IEEE_DIV_ROUND_NEAREST_EN
    localparam int QW = MW + 2;
`else
    localparam int QW = MW + 1;
`endif

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t             state;
    logic               sign;
    logic signed [9:0]  exp;
    logic [MW-1:0]      mb;
    logic [MW:0]        rem;
    logic [QW-1:0]      q;
    logic [4:0]         cnt;

    logic [EW-1:0]      ea, eb;
    logic               sign_in;
    logic               spec;
    logic [31:0]        spec_q;
    logic               spec_dbz;

    assign ea      = dividend[30:MANT_W];
    assign eb      = divisor[30:MANT_W];
    assign sign_in = dividend[31] ^ divisor[31];

    always_comb begin
        spec     = 1'b1;
        spec_q   = 32'h7FC0_0000;
        spec_dbz = 1'b0;
        if (ea == '1 || eb == '1) begin
            spec_q = 32'h7FC0_0000;
        end else if (ea == '0 && eb == '0) begin
            spec_q = 32'h7FC0_0000;
        end else if (eb == '0) begin
            spec_q   = {sign_in, {EW{1'b1}}, {MANT_W{1'b0}}};
            spec_dbz = 1'b1;
        end else if (ea == '0) begin
            spec_q = {sign_in, 31'b0};
        end else begin
            spec = 1'b0;
        end
    end

    logic          q_bit;
    logic [MW:0]   rem_nxt;

    assign q_bit   = rem >= {1'b0, mb};
    assign rem_nxt = q_bit ? rem - {1'b0, mb} : rem;

    logic                msb;
    logic [MANT_W-1:0]   frac;
    logic                carry;
    logic signed [9:0]   exp_n;
    logic [31:0]         norm_q;

    assign msb = q[QW-1];

    always_comb begin
        frac  = '0;
        carry = 1'b0;
`ifdef IEEE_DIV_ROUND_NEAREST_EN
        begin
            logic [MANT_W-1:0] keep;
            logic              guard, sticky, up;
            logic [MANT_W:0]   sum;
            keep   = msb ? q[QW-2:2] : q[QW-3:1];
            guard  = msb ? q[1] : q[0];
            sticky = (msb & q[0]) | (|rem);
            up     = guard & (sticky | keep[0]);
            sum    = {1'b0, keep} + {{MANT_W{1'b0}}, up};
            // all-ones mantissa rolls over to 1.0 x 2^(e+1): fraction becomes zero
            carry  = sum[MANT_W];
            frac   = sum[MANT_W-1:0];
        end
`else
        frac = msb ? q[QW-2:1] : q[QW-3:0];
`endif
        exp_n  = exp - {9'b0, ~msb} + {9'b0, carry};
        norm_q = {sign, exp_n[EW-1:0], frac};
        if (exp_n >= 10'sd255)
            norm_q = {sign, {EW{1'b1}}, {MANT_W{1'b0}}};
        else if (exp_n <= 10'sd0)
            norm_q = {sign, 31'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            sign        <= 1'b0;
            exp         <= '0;
            mb          <= '0;
            rem         <= '0;
            q           <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign     <= sign_in;
                        exp      <= 10'(ea) - 10'(eb) + 10'(EXP_BIAS);
                        mb       <= {1'b1, divisor[MANT_W-1:0]};
                        rem      <= {2'b01, dividend[MANT_W-1:0]};
                        q        <= '0;
                        cnt      <= '0;
                        if (spec) begin
                            quotient    <= spec_q;
                            div_by_zero <= spec_dbz;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q   <= {q[QW-2:0], q_bit};
                    rem <= rem_nxt << 1;
                    if (cnt == 5'(QW - 1))
                        state <= NORM;
                    else
                        cnt <= cnt + 5'd1;
                end
                NORM: begin
                    quotient    <= norm_q;
                    div_by_zero <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ieee_div.sv
// Randomized self-checking bench for ieee_div against an arithmetic quotient model.
module tb_ieee_div;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] quotient;
    logic        div_by_zero;

    int tests = 0;
    int fails = 0;

`ifdef IEEE_DIV_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
    localparam int LAT = 28;
`else
    localparam bit RNE = 1'b0;
    localparam int LAT = 27;
`endif

    ieee_div dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Quotient from exact integer division of the significands, then normalise/round.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic dbz, output int lat);
        int ea, eb, e, sh;
        logic s, guard, sticky;
        longint unsigned ma, mb, n, qq, rr, m;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        dbz = 1'b0;
        lat = 1;
        if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
            q = 32'h7FC00000;
        end else if (eb == 0) begin
            q = {s, 8'hFF, 23'h0};
            dbz = 1'b1;
        end else if (ea == 0) begin
            q = {s, 31'h0};
        end else begin
            lat = LAT;
            ma = (64'd1 << 23) | 64'(a[22:0]);
            mb = (64'd1 << 23) | 64'(b[22:0]);
            n  = ma << 26;
            qq = n / mb;
            rr = n % mb;
            e  = ea - eb + 127;
            if (qq >= (64'd1 << 26)) sh = 3;
            else begin sh = 2; e = e - 1; end
            m      = qq >> sh;
            guard  = ((qq >> (sh - 1)) & 64'd1) != 0;
            sticky = ((qq & ((64'd1 << (sh - 1)) - 1)) != 0) || (rr != 0);
            if (RNE && guard && (sticky || ((m & 64'd1) != 0))) m = m + 1;
            if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e = e + 1; end
            if (e >= 255)     q = {s, 8'hFF, 23'h0};
            else if (e <= 0)  q = {s, 31'h0};
            else              q = {s, 8'(e), 23'(m)};
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic [31:0] q, output logic dbz, output int lat);
        int n;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        q   = quotient;
        dbz = div_by_zero;
        if (hold > 0) begin
            dividend = 32'h3F800000;
            divisor  = 32'h3F800000;
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_quotient", quotient, q);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_out_valid", 32'(out_valid), 32'd1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, wq;
        logic dbz, wdbz;
        int lat, wlat;
        model(a, b, wq, wdbz, wlat);
        run_op(a, b, 0, q, dbz, lat);
        check({tag, "_q"}, q, wq);
        check({tag, "_dbz"}, 32'(dbz), 32'(wdbz));
        check({tag, "_lat"}, 32'(lat), 32'(wlat));
    endtask

    function automatic logic [31:0] rnd_fp();
        int e;
        if ($urandom_range(0, 15) == 0) e = $urandom_range(0, 1) ? 255 : 0;
        else e = $urandom_range(1, 254);
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] q;
        logic dbz;
        int lat;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", quotient, 32'h0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h40C00000, 32'h40000000, 0, q, dbz, lat);
        check("6div2_q", q, 32'h40400000);
        check("6div2_dbz", 32'(dbz), 32'd0);
        check("6div2_lat", 32'(lat), 32'(LAT));

        run_op(32'h3F800000, 32'h40400000, 0, q, dbz, lat);
        check("1div3_q", q, RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA);

        run_op(32'hC1000000, 32'h3F000000, 0, q, dbz, lat);
        check("m8div05_q", q, 32'hC1800000);

        run_op(32'h3F800000, 32'h00000000, 0, q, dbz, lat);
        check("1div0_q", q, 32'h7F800000);
        check("1div0_dbz", 32'(dbz), 32'd1);
        check("1div0_lat", 32'(lat), 32'd1);

        run_op(32'h7F000000, 32'h3F000000, 0, q, dbz, lat);
        check("ovf_q", q, 32'h7F800000);
        check("ovf_dbz", 32'(dbz), 32'd0);

        directed("negdiv0", 32'hBF800000, 32'h00000000);
        directed("zerodiv", 32'h00000000, 32'h3F800000);
        directed("zerozero", 32'h00000000, 32'h00000000);
        directed("infdiv", 32'h7F800000, 32'h3F800000);
        directed("underflow", 32'h00800000, 32'h7E800000);

        run_op(32'h40C00000, 32'h40000000, 10, q, dbz, lat);
        check("bp_q", q, 32'h40400000);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("bp_no_extra", 32'(seen), 32'd0);

        @(negedge clk);
        dividend = 32'h40C00000;
        divisor  = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_quotient", quotient, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("midrst_no_stale", 32'(seen), 32'd0);
        directed("fresh6div2", 32'h40C00000, 32'h40000000);

        for (int i = 0; i < 100; i++) begin
            directed("rand", rnd_fp(), rnd_fp());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ieee_div.md
Name: ieee_div

Overview:
- Iterative IEEE-754 single-precision divider.
- It is the inverse operation of the team's combinational single-precision multiplier and sits alongside it in the processing datapath.
- It accepts one operand pair through a valid/ready handshake and produces the quotient with one quotient bit per cycle from a restoring mantissa divider.
- It returns the result through a second valid/ready handshake. There is one operation in flight at a time.

Parameters:
- EXP_BIAS, 127, exponent bias used when rebuilding the result exponent.
- MANT_W, 23, stored fraction width. Fixed for single precision; only exercised at 23.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block idle and able to accept
- dividend  input  32  IEEE-754 single dividend
- divisor  input  32  IEEE-754 single divisor
- out_valid  output  1  quotient valid
- out_ready  input  1  downstream accepts quotient
- quotient  output  32  IEEE-754 single result
- div_by_zero  output  1  result came from a finite nonzero dividend over a zero divisor; valid with out_valid

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, in_ready=1, out_valid=0, quotient=0, div_by_zero=0.
  - All internal registers are cleared.
- States: IDLE -> (CALC | DONE) -> NORM -> DONE -> IDLE. The special-case path goes IDLE -> DONE directly.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture operands, sign=dividend[31]^divisor[31], and exponent ea-eb+EXP_BIAS in 10-bit signed.
  - Load mantissas {1,frac}, 24-bit each.
- Special cases, decided in the accept cycle, go to DONE next cycle (latency 1):
  - Either exponent field is 255 -> quotient=0x7FC00000 (canonical NaN, sign 0).
  - Dividend exponent field is 0 and divisor exponent field is 0 -> 0x7FC00000.
  - Divisor exponent field is 0 -> {sign,0x7F800000[30:0]}, div_by_zero=1.
  - Dividend exponent field is 0 -> {sign,31'b0}.
  - Denormal inputs are treated as zero.
- CALC (restoring division):
  - Remainder starts at the dividend mantissa, 25 bits.
  - Each cycle: if rem>=mb then q bit=1 and rem-=mb, else q bit=0; then rem<<=1.
  - 25 cycles produce q[24:0], MSB first. A 5-bit counter terminates the loop.
- NORM:
  - If q[24]=1: fraction=q[23:1], exponent unchanged.
  - Else: fraction=q[22:0], exponent-=1.
  - Rounding is truncation (round toward zero).
  - Exponent >=255 -> signed infinity {sign,8'hFF,23'b0}.
  - Exponent <=0 -> signed zero (flush, no denormal output).
- DONE:
  - out_valid=1; quotient and div_by_zero are held stable until out_ready=1.
  - On out_valid&out_ready: out_valid drops the next cycle and the block returns to IDLE.
  - The result and in_ready rise together one cycle later; there is no same-cycle accept.
- Latency for the normal path: out_valid rises 27 cycles after the accepting edge (25 CALC + 1 NORM + 1 register).
- in_ready=0 in every state except IDLE. in_valid is ignored while busy.
- Reset asserted mid-operation:
  - The operation in flight is discarded.
  - Outputs return to reset values immediately (asynchronously).
  - No result is delivered after reset releases.

Optional Feature:
- Macro: IEEE_DIV_ROUND_NEAREST_EN.
- Defined:
  - CALC runs 26 iterations to produce a round bit. A sticky bit is set when the final remainder is nonzero.
  - NORM applies round-to-nearest-even. A mantissa carry-out increments the exponent before the overflow check.
  - Normal-path latency becomes 28.
- Undefined: truncation with latency 27, as specified above.

Test Plan:
- 0x40C00000 (6.0) / 0x40000000 (2.0) -> quotient 0x40400000, div_by_zero=0, out_valid exactly 27 cycles after accept (28 with the macro).
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA without the macro; 0x3EAAAAAB with IEEE_DIV_ROUND_NEAREST_EN.
- 0xC1000000 (-8.0) / 0x3F000000 (0.5) -> 0xC1800000.
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1, out_valid 1 cycle after accept. 0x7F000000 / 0x3F000000 -> 0x7F800000 (overflow), div_by_zero=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> quotient stable, in_ready=0, and a new in_valid is not accepted.
  - Raise out_ready -> out_valid falls next cycle and in_ready returns.
- Drop rst_n during CALC cycle 10 -> out_valid=0 and in_ready=1 immediately. After release, no stale quotient appears and a fresh 6.0/2.0 returns 0x40400000.
